bit_serial_adder: RTL and testbench
===================================

Name: bit_serial_adder

Overview:
Sequential adder that computes {cout,sum} = a + b + cin one bit per clock, LSB first, using a single fa cell and a carry flip-flop. It is the next stage built on the fa cell: it supplies fa's a/b/cin each cycle and consumes its sum/cout. It trades WIDTH-cycle latency for one-bit datapath area, with a start/done handshake to the controlling logic.

Parameters:
WIDTH, 8, operand and result width in bits (legal: >= 1)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden)

Ports:
clk    input   1      system clock, rising-edge active
rst_n  input   1      asynchronous active-low reset
start  input   1      request; sampled only in IDLE
a      input   WIDTH  operand A, sampled on the accepting edge
b      input   WIDTH  operand B, sampled on the accepting edge
cin    input   1      carry-in, sampled on the accepting edge
busy   output  1      1 while the operation is in progress (SHIFT)
done   output  1      one-cycle pulse: result just updated
sum    output  WIDTH  result low WIDTH bits; held until next completion
cout   output  1      result carry-out; held until next completion

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n); all state clears immediately on rst_n=0, independent of clk.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift regs/counter/carry=0.
- Internal regs: a_sh, b_sh (WIDTH), carry (1), acc_sh (WIDTH), cnt (CNT_W). The fa instance is driven by a_sh[0], b_sh[0], carry.
- FSM states:
  - IDLE: busy=0. If start=1 on edge E0: load a_sh=a, b_sh=b, carry=cin, cnt=0 -> SHIFT. Otherwise stay.
  - SHIFT: busy=1. Each edge: acc_sh={fa.sum, acc_sh[WIDTH-1:1]}; carry=fa.cout; a_sh>>=1; b_sh>>=1; cnt++.
  - On the edge where cnt==WIDTH-1 (edge E_WIDTH): sum<=final acc_sh value including this bit; cout<=fa.cout; done<=1 -> DONE.
  - DONE: done=1 for exactly this cycle, busy=0. Next edge -> IDLE, done<=0. start is ignored in DONE.
- Latency: start accepted at E0; bits computed at E1..E_WIDTH; sum/cout/done update at E_WIDTH; done falls at E_WIDTH+1. Minimum issue interval is WIDTH+2 cycles.
- Arithmetic: {cout,sum} equals the full (WIDTH+1)-bit value of a+b+cin; no truncation or overflow flag.
- start while busy=1 or done=1: ignored, with no effect on the operation in flight. The operands are not re-sampled.
- a/b/cin changing after E0: no effect; the operands are captured.
- sum/cout change only at the completion edge or reset. Between operations they hold the last result. They do not glitch during SHIFT.
- Reset mid-operation: abort and return to IDLE with all outputs 0. No done pulse is issued for the aborted operation.
- WIDTH=1: the SHIFT state lasts a single edge. The result equals the fa truth table.

Test Plan:
- Reset: rst_n=0 asserted asynchronously between clk edges -> busy=0, done=0, sum=0, cout=0 immediately. Hold IDLE 3 cycles with start=0 -> outputs unchanged.
- Basic (WIDTH=8): a=8'h3C, b=8'h0F, cin=0, start pulse at E0 -> busy=1 for E1..E8, done=1 in cycle after E8, sum=8'h4B, cout=0. Values held after done falls.
- Carry ripple: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1. Then a=8'h80, b=8'h80, cin=1 -> sum=8'h01, cout=1.
- Protocol: start held high continuously, and operands changed on E3 -> exactly one done per WIDTH+2 cycles; each result matches operands captured at acceptance. start during DONE is not accepted.
- Reset mid-op: start a=8'hFF, b=8'hFF, cin=1; drop rst_n at E4 -> no done, sum=0, cout=0. Next op a=8'h12, b=8'h34, cin=0 -> sum=8'h46, cout=0.
- WIDTH=1 exhaustive: all 8 {a,b,cin} combos -> {cout,sum} matches 0,1,1,2,1,2,2,3, with done one edge after acceptance.

Source files
------------

// File: rtl/bit_serial_adder_if.sv
// rtl/bit_serial_adder_if.sv - start/done handshake and operand/result bundle for bit_serial_adder
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Controller side: issues operands and start, observes progress and result
  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  // Adder side: consumes operands, reports progress and result
  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - LSB-first bit-serial adder built on a single fa cell
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  // One-bit full adder
  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end
endmodule

module bit_serial_adder #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  bit_serial_adder_if.slave  bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Count value on the edge that computes the final (MSB) bit
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc_sh;
  logic [WIDTH-1:0] acc_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             fa_sum;
  logic             fa_cout;

  fa u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New result bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB
  if (WIDTH == 1) begin : g_acc_one
    assign acc_nxt = fa_sum;
  end else begin : g_acc_many
    assign acc_nxt = {fa_sum, acc_sh[WIDTH-1:1]};
  end

  // Handshake FSM plus serial datapath; sum/cout only move on the completion edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      acc_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc_sh <= acc_nxt;
          carry  <= fa_cout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            sum_q  <= acc_nxt;
            cout_q <= fa_cout;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_bit_serial_adder.sv
// tb/tb_bit_serial_adder.sv - self-checking bench for bit_serial_adder (WIDTH=8 and WIDTH=1)
module tb_bit_serial_adder;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  logic chk_en;

  bit_serial_adder_if #(.WIDTH(8)) bus8 ();
  bit_serial_adder_if #(.WIDTH(1)) bus1 ();

  bit_serial_adder #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  bit_serial_adder #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: result = a+b+cin captured at acceptance, published WIDTH edges later
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [7:0] m_sum  = '0;
  logic       m_cout = 1'b0;
  logic [8:0] m_pend = '0;
  int         m_rem  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_rem  <= 0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      if (m_rem == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        {m_cout, m_sum} <= m_pend;
      end else begin
        m_rem <= m_rem - 1;
      end
    end else if (bus8.start) begin
      m_pend <= 9'(bus8.a) + 9'(bus8.b) + 9'(bus8.cin);
      m_rem  <= 8;
      m_busy <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 32'(bus8.busy), 32'(m_busy));
      chk("cyc_done", 32'(bus8.done), 32'(m_done));
      chk("cyc_sum",  32'(bus8.sum),  32'(m_sum));
      chk("cyc_cout", 32'(bus8.cout), 32'(m_cout));
    end
  end

  // Issue one op on the 8-bit DUT, require done after exactly 8 edges, check literal result
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [8:0] exp);
    int  n;
    logic got;
    @(posedge clk); #2;
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin;
    @(posedge clk); #2;
    bus8.start = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (bus8.done) got = 1'b1;
    end
    chk({name, "_done_seen"}, 32'(got), 32'd1);
    chk({name, "_latency"}, 32'(n), 32'd9);
    chk({name, "_result"}, 32'({bus8.cout, bus8.sum}), 32'(exp));
    @(negedge clk);
    chk({name, "_done_fall"}, 32'(bus8.done), 32'd0);
    chk({name, "_held"}, 32'({bus8.cout, bus8.sum}), 32'(exp));
  endtask

  logic [1:0] tbl [8];
  int         dcount;
  int         dpos [3];
  logic [8:0] dres [3];

  initial begin
    n_pass = 0; n_total = 0; chk_en = 1'b0;
    rst_n = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    tbl = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    // Asynchronous reset between edges
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_done", 32'(bus8.done), 32'd0);
    chk("rst_sum",  32'(bus8.sum),  32'd0);
    chk("rst_cout", 32'(bus8.cout), 32'd0);
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("idle_sum", 32'({bus8.cout, bus8.sum}), 32'd0);

    run_op("basic",   8'h3C, 8'h0F, 1'b0, 9'h04B);
    run_op("ripple1", 8'hFF, 8'h01, 1'b0, 9'h100);
    run_op("ripple2", 8'hA5, 8'h5A, 1'b1, 9'h100);
    run_op("ripple3", 8'h80, 8'h80, 1'b1, 9'h101);

    // start held high; operands change after E3 of the first op
    @(posedge clk); #2;
    bus8.start = 1'b1; bus8.a = 8'h11; bus8.b = 8'h22; bus8.cin = 1'b0;
    @(posedge clk);
    dcount = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 4) begin
        bus8.a = 8'h01; bus8.b = 8'hFF; bus8.cin = 1'b1;
      end
      if (bus8.done) begin
        if (dcount < 3) begin
          dpos[dcount] = c;
          dres[dcount] = {bus8.cout, bus8.sum};
        end
        dcount++;
      end
    end
    bus8.start = 1'b0;
    chk("proto_count", 32'(dcount), 32'd3);
    chk("proto_pos0", 32'(dpos[0]), 32'd9);
    chk("proto_pos1", 32'(dpos[1]), 32'd19);
    chk("proto_pos2", 32'(dpos[2]), 32'd29);
    chk("proto_res0", 32'(dres[0]), 32'h033);
    chk("proto_res1", 32'(dres[1]), 32'h101);
    chk("proto_res2", 32'(dres[2]), 32'h101);
    repeat (2) @(posedge clk);

    // Reset mid-operation at E4
    @(posedge clk); #2;
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1;
    @(posedge clk); #2;
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus8.busy), 32'd0);
    chk("abort_done", 32'(bus8.done), 32'd0);
    chk("abort_res",  32'({bus8.cout, bus8.sum}), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus8.done) dcount++;
    end
    chk("abort_no_done", 32'(dcount), 32'd0);
    run_op("after_abort", 8'h12, 8'h34, 1'b0, 9'h046);

    // WIDTH=1 exhaustive truth table
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      bus1.start = 1'b1; bus1.a = 1'(i >> 2); bus1.b = 1'(i >> 1); bus1.cin = 1'(i);
      @(posedge clk); #2;
      bus1.start = 1'b0;
      @(negedge clk);
      chk($sformatf("w1_busy_%0d", i), 32'({bus1.busy, bus1.done}), 32'b10);
      @(negedge clk);
      chk($sformatf("w1_done_%0d", i), 32'(bus1.done), 32'd1);
      chk($sformatf("w1_res_%0d", i), 32'({bus1.cout, bus1.sum}), 32'(tbl[i]));
    end
    repeat (2) @(posedge clk);
    #2;
    chk("w1_held", 32'({bus1.cout, bus1.sum}), 32'(tbl[7]));

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
